// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and constants for the sdram request arbiter
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_ACK   = 2'd1,
        WAIT_VALID = 2'd2
    } arb_state_t;

    // Sized for the largest supported port count (8) so owner fields never change width.
    localparam int OWNER_WIDTH = 3;

endpackage

// File: rtl/sdram_arbiter_rr_pick.sv
// rtl/sdram_arbiter_rr_pick.sv - round-robin selector over ports 1..NUM_PORTS-1
module rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0]   req_mask,
    input  logic [OWNER_WIDTH-1:0] last_grant,
    output logic [OWNER_WIDTH-1:0] winner,
    output logic                   any
);

    logic [NUM_PORTS-1:0] shifted;
    int                   cand;

    // Walk the ring 1..N-1 starting just after last_grant; bit 0 is never considered here.
    always_comb begin
        winner  = '0;
        any     = 1'b0;
        shifted = '0;
        cand    = 0;
        for (int k = 0; k < NUM_PORTS - 1; k++) begin
            cand    = ((int'(last_grant) + k) % (NUM_PORTS - 1)) + 1;
            shifted = req_mask >> cand;
            if (!any && shifted[0]) begin
                any    = 1'b1;
                winner = cand[OWNER_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - shares one sdram controller port among NUM_PORTS requesters
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            port_req,
    input  logic [NUM_PORTS-1:0]            port_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_data,
    output logic [NUM_PORTS-1:0]            port_ack,
    output logic [NUM_PORTS-1:0]            port_valid,
    output logic [DATA_WIDTH-1:0]           port_q,
    output logic [ADDR_WIDTH-1:0]           sdram_addr,
    output logic [DATA_WIDTH-1:0]           sdram_data,
    output logic                            sdram_we,
    output logic                            sdram_req,
    input  logic                            sdram_ack,
    input  logic                            sdram_valid,
    input  logic [DATA_WIDTH-1:0]           sdram_q,
    output logic                            busy,
    output logic                            timeout
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t             state_q, state_d;
    logic [OWNER_WIDTH-1:0] owner_q, owner_d;
    logic [OWNER_WIDTH-1:0] last_grant_q, last_grant_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   we_q, we_d;
    logic                   timeout_q, timeout_d;

    logic [OWNER_WIDTH-1:0] rr_winner;
    logic                   rr_any;
    logic [OWNER_WIDTH-1:0] grant_idx;
    logic [NUM_PORTS-1:0]   owner_oh;

    rr_pick #(.NUM_PORTS(NUM_PORTS)) u_rr_pick (
        .req_mask   (port_req),
        .last_grant (last_grant_q),
        .winner     (rr_winner),
        .any        (rr_any)
    );

    assign grant_idx = port_req[0] ? '0 : rr_winner;
    assign owner_oh  = NUM_PORTS'(1) << owner_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        data_d       = data_q;
        we_d         = we_q;
        timeout_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (port_req[0] || rr_any) begin
                    owner_d = grant_idx;
                    addr_d  = ADDR_WIDTH'(port_addr >> (int'(grant_idx) * ADDR_WIDTH));
                    data_d  = DATA_WIDTH'(port_data >> (int'(grant_idx) * DATA_WIDTH));
                    we_d    = 1'(port_we >> grant_idx);
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (sdram_ack) begin
                    // Port 0 bypasses the ring, so it must not disturb the rotation.
                    if (owner_q != '0) begin
                        last_grant_d = owner_q;
                    end
                    cnt_d   = '0;
                    state_d = we_q ? IDLE : WAIT_VALID;
                end
            end
            WAIT_VALID: begin
                if (sdram_valid) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_grant_q <= OWNER_WIDTH'(NUM_PORTS - 1);
            cnt_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            we_q         <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            we_q         <= we_d;
            timeout_q    <= timeout_d;
        end
    end

    assign sdram_req  = (state_q == WAIT_ACK);
    assign busy       = (state_q != IDLE);
    assign sdram_addr = addr_q;
    assign sdram_data = data_q;
    assign sdram_we   = we_q;
    assign timeout    = timeout_q;
    assign port_q     = sdram_q;
    assign port_ack   = (state_q == WAIT_ACK   && sdram_ack)   ? owner_oh : '0;
    assign port_valid = (state_q == WAIT_VALID && sdram_valid) ? owner_oh : '0;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - self-checking bench for sdram_arbiter
module tb_sdram_arbiter;

    localparam int NP = 4;
    localparam int AW = 23;
    localparam int DW = 32;
    localparam int TO = 64;

    logic             clk;
    logic             reset;
    logic [NP-1:0]    port_req;
    logic [NP-1:0]    port_we;
    logic [NP*AW-1:0] port_addr;
    logic [NP*DW-1:0] port_data;
    logic [NP-1:0]    port_ack;
    logic [NP-1:0]    port_valid;
    logic [DW-1:0]    port_q;
    logic [AW-1:0]    sdram_addr;
    logic [DW-1:0]    sdram_data;
    logic             sdram_we;
    logic             sdram_req;
    logic             sdram_ack;
    logic             sdram_valid;
    logic [DW-1:0]    sdram_q;
    logic             busy;
    logic             timeout;

    sdram_arbiter #(
        .NUM_PORTS  (NP),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .port_req    (port_req),
        .port_we     (port_we),
        .port_addr   (port_addr),
        .port_data   (port_data),
        .port_ack    (port_ack),
        .port_valid  (port_valid),
        .port_q      (port_q),
        .sdram_addr  (sdram_addr),
        .sdram_data  (sdram_data),
        .sdram_we    (sdram_we),
        .sdram_req   (sdram_req),
        .sdram_ack   (sdram_ack),
        .sdram_valid (sdram_valid),
        .sdram_q     (sdram_q),
        .busy        (busy),
        .timeout     (timeout)
    );

    typedef struct {
        int            port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        int            port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] rdata;
        int            ack_dly;
        int            val_dly;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[6];
    int   n_vec = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic raise(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        port_req[p]          = 1'b1;
        port_we[p]           = we;
        port_addr[p*AW +: AW] = a;
        port_data[p*DW +: DW] = d;
        sbq.push_back('{p, we, a, d});
    endtask

    task automatic wait_req(output exp_t e, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (sdram_req !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        lat = w;
        check("sdram_req_seen", sdram_req, 1);
        if (sbq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: grant with empty queue");
            e = '{0, 1'b0, '0, '0};
        end else begin
            e = sbq.pop_front();
            check("sdram_addr", sdram_addr, e.addr);
            check("sdram_we", sdram_we, e.we);
            if (e.we) check("sdram_data", sdram_data, e.data);
        end
    endtask

    task automatic serve(input bit rearm, input int ack_dly, input int val_dly,
                         input logic [DW-1:0] rq, output int lat);
        exp_t e;
        wait_req(e, lat);
        // Spurious controller valid while waiting for ack must not reach any port.
        for (int i = 0; i < ack_dly; i++) begin
            @(posedge clk);
            #1 sdram_valid = 1'b1;
            sdram_q = 32'hBAD0_0000 | i;
            @(negedge clk);
            check("valid_in_wait_ack", port_valid, 0);
            check("req_held", sdram_req, 1);
            check("addr_held", sdram_addr, e.addr);
        end
        @(posedge clk);
        #1 sdram_valid = 1'b0;
        sdram_ack = 1'b1;
        @(negedge clk);
        check("port_ack", port_ack, 64'd1 << e.port);
        @(posedge clk);
        #1 sdram_ack = 1'b0;
        port_req[e.port] = 1'b0;
        if (!e.we) begin
            repeat (val_dly) @(posedge clk);
            #1 sdram_valid = 1'b1;
            sdram_q = rq;
            @(negedge clk);
            check("port_valid", port_valid, 64'd1 << e.port);
            check("port_q", port_q, rq);
            @(posedge clk);
            #1 sdram_valid = 1'b0;
        end
        @(negedge clk);
        check("busy_after", busy, 0);
        check("port_valid_idle", port_valid, 0);
        if (rearm) begin
            @(posedge clk);
            #1 raise(e.port, e.we, e.addr, e.data);
        end
    endtask

    initial begin
        exp_t e;
        int   lat;

        tbl[0] = '{2, 1'b0, 23'h000123, 32'h0,        32'hDEADBEEF, 1, 4};
        tbl[1] = '{0, 1'b1, 23'h7FFFFF, 32'h01020304, 32'h0,        0, 0};
        tbl[2] = '{3, 1'b0, 23'h400000, 32'h0,        32'h12345678, 0, 0};
        tbl[3] = '{1, 1'b1, 23'h000001, 32'hA5A5A5A5, 32'h0,        3, 0};
        tbl[4] = '{0, 1'b0, 23'h2AAAAA, 32'h0,        32'hFFFFFFFF, 2, 7};
        tbl[5] = '{3, 1'b1, 23'h155555, 32'h5A5A5A5A, 32'h0,        0, 0};

        reset       = 1'b1;
        port_req    = '0;
        port_we     = '0;
        port_addr   = '0;
        port_data   = '0;
        sdram_ack   = 1'b0;
        sdram_valid = 1'b0;
        sdram_q     = '0;

        repeat (2) @(negedge clk);
        check("rst_sdram_req", sdram_req, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        check("rst_port_ack", port_ack, 0);
        check("rst_sdram_addr", sdram_addr, 0);
        check("rst_sdram_we", sdram_we, 0);
        reset = 1'b0;

        // Port 0 beats everyone; 1 then 3 because last_grant starts at NP-1.
        @(posedge clk);
        #1 raise(0, 1'b1, 23'h000100, 32'h00000000);
        raise(1, 1'b1, 23'h000111, 32'h11111111);
        raise(3, 1'b1, 23'h000333, 32'h33333333);
        for (int i = 0; i < 3; i++) serve(1'b0, 0, 0, '0, lat);

        // Ports 1..3 keep re-requesting; expected order rotates 1,2,3.
        @(posedge clk);
        #1 raise(1, 1'b1, 23'h010001, 32'hC0000001);
        raise(2, 1'b1, 23'h010002, 32'hC0000002);
        raise(3, 1'b1, 23'h010003, 32'hC0000003);
        for (int i = 0; i < 9; i++) serve(i < 6, i % 2, 0, '0, lat);

        for (int v = 0; v < 6; v++) begin
            @(posedge clk);
            #1 raise(tbl[v].port, tbl[v].we, tbl[v].addr, tbl[v].data);
            @(negedge clk);
            check("grant_not_early", sdram_req, 0);
            serve(1'b0, tbl[v].ack_dly, tbl[v].val_dly, tbl[v].rdata, lat);
            check("grant_latency", lat, 0);
        end

        // Read with no controller response: abandoned after TO cycles in WAIT_VALID.
        @(posedge clk);
        #1 raise(1, 1'b0, 23'h0F0F0F, 32'h0);
        wait_req(e, lat);
        @(posedge clk);
        #1 sdram_ack = 1'b1;
        @(posedge clk);
        #1 sdram_ack = 1'b0;
        port_req[1] = 1'b0;
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            if (k == TO - 1) begin
                check("timeout_not_early", timeout, 0);
                check("busy_before_timeout", busy, 1);
            end
        end
        @(negedge clk);
        check("timeout_pulse", timeout, 1);
        check("busy_at_timeout", busy, 0);
        @(negedge clk);
        check("timeout_one_cycle", timeout, 0);
        repeat (3) @(posedge clk);
        #1 sdram_valid = 1'b1;
        sdram_q = 32'hCAFEF00D;
        @(negedge clk);
        check("late_valid_dropped", port_valid, 0);
        @(posedge clk);
        #1 sdram_valid = 1'b0;

        // Reset mid WAIT_VALID: outputs drop at once, rotation restarts at port 1.
        @(posedge clk);
        #1 raise(1, 1'b0, 23'h0ABCDE, 32'h0);
        wait_req(e, lat);
        @(posedge clk);
        #1 sdram_ack = 1'b1;
        @(posedge clk);
        #1 sdram_ack = 1'b0;
        port_req[1] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("busy_in_wait_valid", busy, 1);
        #2 reset = 1'b1;
        sdram_valid = 1'b1;
        sdram_q = 32'h0BADBEEF;
        #1;
        check("mid_rst_sdram_req", sdram_req, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_port_valid", port_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        #2 check("valid_after_reset", port_valid, 0);
        @(posedge clk);
        #1 sdram_valid = 1'b0;
        raise(1, 1'b1, 23'h000AAA, 32'hAAAA0001);
        raise(2, 1'b1, 23'h000BBB, 32'hBBBB0002);
        serve(1'b0, 0, 0, '0, lat);
        serve(1'b0, 0, 0, '0, lat);

        check("scoreboard_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller request port (addr/data/we/req/ack/valid/q) among NUM_PORTS requesters.
- Typical requesters: ROM download writer, CPU program ROM, tile/sprite ROM fetchers.
- Port 0 has absolute priority (download). Ports 1..NUM_PORTS-1 are served round-robin.
- One transaction in flight. Read data is routed back to its owner. Sits between the game top level and the sdram controller.

Parameters:
- NUM_PORTS, 4, number of requesters (2..8); port 0 has fixed top priority.
- ADDR_WIDTH, 23, SDRAM word address width.
- DATA_WIDTH, 32, write/read data width.
- TIMEOUT, 64, maximum cycles spent in WAIT_VALID before the read is abandoned.

Ports:
- clk  in  1  system clock (96 MHz)
- reset  in  1  asynchronous, active-high reset
- port_req  in  NUM_PORTS  per-port request level; held high until that port's ack
- port_we  in  NUM_PORTS  per-port write enable; sampled with req
- port_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address, port i at slice i
- port_data  in  NUM_PORTS*DATA_WIDTH  per-port write data, port i at slice i
- port_ack  out  NUM_PORTS  one-cycle pulse: the owner's command was accepted
- port_valid  out  NUM_PORTS  one-cycle pulse: read data for the owner is on port_q
- port_q  out  DATA_WIDTH  read data, broadcast to all ports
- sdram_addr  out  ADDR_WIDTH  latched address to the controller
- sdram_data  out  DATA_WIDTH  latched write data to the controller
- sdram_we  out  1  latched write enable
- sdram_req  out  1  request to the controller
- sdram_ack  in  1  controller accepted the command
- sdram_valid  in  1  controller read data valid
- sdram_q  in  DATA_WIDTH  controller read data
- busy  out  1  state != IDLE
- timeout  out  1  one-cycle pulse when a read is abandoned

Behaviour:
- States: IDLE, WAIT_ACK, WAIT_VALID.
- IDLE:
  - If any port_req bit is set, pick the winner. Port 0 wins if it is requesting. Otherwise take the first requesting port at or after last_grant+1 among 1..NUM_PORTS-1, wrapping.
  - Register owner, addr, data and we. Go to WAIT_ACK.
  - Grant takes 1 cycle: a req seen at cycle N gives sdram_req=1 at N+1.
- WAIT_ACK:
  - sdram_req=1 with the latched addr/data/we. These are stable until ack, whatever the requester does.
  - On sdram_ack: port_ack[owner]=1 in the same cycle (combinational: sdram_ack & owner one-hot).
  - If we=1, go to IDLE. Otherwise go to WAIT_VALID and clear the timeout counter.
  - last_grant is updated only when ack arrives for a port other than 0.
- WAIT_VALID:
  - sdram_req=0.
  - On sdram_valid: port_valid[owner]=1 in the same cycle, then go to IDLE.
  - port_q = sdram_q always (pass-through).
  - If the counter reaches TIMEOUT-1 with no valid: pulse timeout and go to IDLE. A late sdram_valid arriving in IDLE or WAIT_ACK is dropped; no port_valid is raised.
- Requester contract:
  - Keep req high until ack, then drop it on the next edge.
  - Because ack is combinational, req is already low when the arbiter is back in IDLE, so no re-grant occurs.
  - A req dropped before its grant is simply not chosen. Once granted, the request completes.
- sdram_valid while in WAIT_ACK is ignored.
- Simultaneous requests:
  - Port 0 plus others: port 0 wins.
  - Several of ports 1..N-1: round-robin; last_grant resets to NUM_PORTS-1, so port 1 is served first after reset.
- Reset, asynchronous and usable mid-transaction:
  - State=IDLE; owner=0; last_grant=NUM_PORTS-1; counter=0; latched addr/data/we=0.
  - sdram_req=0, port_ack=0, port_valid=0, busy=0, timeout=0.
  - An in-flight controller response after reset is dropped.
- Throughput: 1 idle cycle minimum between transactions (IDLE arbitration cycle).

Decomposition:
- Shared package sdram_arb_pkg:
  - state enum arb_state_t {IDLE, WAIT_ACK, WAIT_VALID}.
  - Constant OWNER_WIDTH = $clog2(NUM_PORTS max 8) = 3.
- One sub-module, rr_pick: combinational round-robin priority selector.
  - Inputs: request mask, last_grant.
  - Outputs: winner index, any.
  - Used for ports 1..N-1; the port-0 override lives in the parent.

Test Plan:
- Single read: port 2 req, addr=0x000123 at cycle 10 → sdram_req at 11 with addr 0x000123, we=0. Ack at 13 → port_ack=0b0100 at 13. Valid with q=0xDEADBEEF at 18 → port_valid=0b0100 at 18, port_q=0xDEADBEEF, busy=0 at 19.
- Priority: ports 0, 1, 3 req in the same cycle → grant order 0, 1, 3. Each sdram_addr matches its port slice.
- Round-robin fairness: ports 1, 2, 3 held requesting (each re-raises after ack) for 9 grants → order 1,2,3,1,2,3,1,2,3. Ports 2/3 never starve.
- Write: port 0 we=1, addr=0x7FFFFF, data=0x01020304 → sdram_we=1 with the same data. Ack → port_ack[0] pulse, IDLE next cycle, no port_valid.
- Timeout: read from port 1 acked, no sdram_valid → timeout pulse exactly TIMEOUT cycles after entering WAIT_VALID, state IDLE. A late sdram_valid 5 cycles later gives port_valid=0.
- Async reset in WAIT_VALID: reset asserted mid-cycle → sdram_req, busy, port_valid go to 0 immediately. After release, port 1 is granted first when ports 1 and 2 both request.
